// File: rtl/fft_tw_mul.sv
// Streaming complex twiddle multiplier for one radix-2 FFT stage.
// Three register stages: capture, partial products, round/saturate.
module fft_tw_mul #(
    parameter int DIN_W   = 10,
    parameter int TW_W    = 9,
    parameter int TW_FRAC = 7,
    parameter int DOUT_W  = 10,
    parameter int N_TW    = 4,
    parameter int ADDR_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din_valid,
    input  logic                     frame_start,
    input  logic signed [DIN_W-1:0]  din_re,
    input  logic signed [DIN_W-1:0]  din_im,
    output logic [ADDR_W-1:0]        tw_addr,
    input  logic signed [TW_W-1:0]   tw_re,
    input  logic signed [TW_W-1:0]   tw_im,
    output logic                     dout_valid,
    output logic signed [DOUT_W-1:0] dout_re,
    output logic signed [DOUT_W-1:0] dout_im,
    output logic                     sat_flag
);

    localparam int PROD_W = DIN_W + TW_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(N_TW - 1);
    localparam logic signed [SUM_W-1:0]  RND       = SUM_W'(2 ** (TW_FRAC - 1));
    localparam logic signed [DOUT_W-1:0] OUT_MAX   = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic signed [DOUT_W-1:0] OUT_MIN   = {1'b1, {(DOUT_W-1){1'b0}}};

    logic [ADDR_W-1:0] idx;
    logic              start;

    logic                    s1_valid;
    logic signed [DIN_W-1:0] s1_re, s1_im;
    logic signed [TW_W-1:0]  s1_twr, s1_twi;

    logic                     s2_valid;
    logic signed [PROD_W-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

    logic signed [SUM_W-1:0]  pre_re, pre_im, sh_re, sh_im;
    logic signed [DOUT_W-1:0] q_re, q_im;
    logic                     clip_re, clip_im;

    // A frame_start sample always uses twiddle 0, even before the counter wraps.
    assign start   = din_valid & frame_start;
    assign tw_addr = start ? '0 : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (din_valid) begin
            idx <= (tw_addr == LAST_ADDR) ? '0 : tw_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_twr   <= '0;
            s1_twi   <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_re  <= din_re;
                s1_im  <= din_im;
                s1_twr <= tw_re;
                s1_twi <= tw_im;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ri    <= '0;
            s2_ir    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_rr <= PROD_W'(s1_re) * PROD_W'(s1_twr);
                s2_ii <= PROD_W'(s1_im) * PROD_W'(s1_twi);
                s2_ri <= PROD_W'(s1_re) * PROD_W'(s1_twi);
                s2_ir <= PROD_W'(s1_im) * PROD_W'(s1_twr);
            end
        end
    end

    // Round half-up then floor-shift; the extra sum bit keeps -max*-max exact.
    function automatic logic [DOUT_W:0] saturate(input logic signed [SUM_W-1:0] v);
        if (v > SUM_W'(OUT_MAX)) begin
            return {1'b1, OUT_MAX};
        end else if (v < SUM_W'(OUT_MIN)) begin
            return {1'b1, OUT_MIN};
        end
        return {1'b0, v[DOUT_W-1:0]};
    endfunction

    always_comb begin
        pre_re = SUM_W'(s2_rr) - SUM_W'(s2_ii);
        pre_im = SUM_W'(s2_ri) + SUM_W'(s2_ir);
        sh_re  = (pre_re + RND) >>> TW_FRAC;
        sh_im  = (pre_im + RND) >>> TW_FRAC;
        {clip_re, q_re} = saturate(sh_re);
        {clip_im, q_im} = saturate(sh_im);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
        end else begin
            dout_valid <= s2_valid;
            if (s2_valid) begin
                dout_re <= q_re;
                dout_im <= q_im;
            end
        end
    end

    // A clip landing on the same edge as a new frame's first sample must survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (s2_valid && (clip_re || clip_im)) begin
            sat_flag <= 1'b1;
        end else if (start) begin
            sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_tw_mul.sv
// Bench for fft_tw_mul: vector table plus random traffic through a scoreboard,
// with a bench-side twiddle ROM, address counter model and sat_flag model.
module tb_fft_tw_mul;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              din_valid;
    logic              frame_start;
    logic signed [9:0] din_re, din_im;
    logic [1:0]        tw_addr;
    logic signed [8:0] tw_re, tw_im;
    logic              dout_valid;
    logic signed [9:0] dout_re, dout_im;
    logic              sat_flag;

    fft_tw_mul dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .frame_start(frame_start),
        .din_re(din_re), .din_im(din_im), .tw_addr(tw_addr), .tw_re(tw_re),
        .tw_im(tw_im), .dout_valid(dout_valid), .dout_re(dout_re),
        .dout_im(dout_im), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Twiddle ROM: idx0..2 = 1.0, idx3 = -j; force mode lets a test drive any twiddle.
    logic signed [8:0] rom_re [4];
    logic signed [8:0] rom_im [4];
    logic              tw_force;
    logic signed [8:0] force_re, force_im;
    assign tw_re = tw_force ? force_re : rom_re[tw_addr];
    assign tw_im = tw_force ? force_im : rom_im[tw_addr];

    typedef struct {
        int due;
        int re;
        int im;
        bit clip;
    } exp_t;

    typedef struct {
        bit v; bit fs; bit frc;
        int re; int im; int twr; int twi;
        int addr; int er; int ei; bit clip;
    } vec_t;

    exp_t sbq[$];
    int   start_q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   midx = 0;
    bit   sat_model = 1'b0;
    bit   sat_next, evt;
    exp_t mon_e;

    always @(posedge clk) cycle = cycle + 1;

    task automatic checkOutput(input string name, input int act, input int req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic int floorDiv128(input int x);
        if (x >= 0) return x / 128;
        return -((-x + 127) / 128);
    endfunction

    function automatic int clamp10(input int x, inout bit clip);
        if (x > 511) begin clip = 1'b1; return 511; end
        if (x < -512) begin clip = 1'b1; return -512; end
        return x;
    endfunction

    function automatic exp_t model(input int re, input int im, input int twr, input int twi);
        exp_t r;
        bit   c = 1'b0;
        r.re   = clamp10(floorDiv128(re * twr - im * twi + 64), c);
        r.im   = clamp10(floorDiv128(re * twi + im * twr + 64), c);
        r.clip = c;
        r.due  = 0;
        return r;
    endfunction

    // eaddr < 0 means "use the bench address model"; useExp selects table expectations.
    task automatic applyStimulus(input bit v, input bit fs, input int re, input int im,
                                 input bit frc, input int twr, input int twi,
                                 input int eaddr, input bit useExp,
                                 input int er, input int ei, input bit eclip);
        int   maddr;
        exp_t e;
        @(negedge clk);
        din_valid   = v;
        frame_start = fs;
        din_re      = 10'(re);
        din_im      = 10'(im);
        tw_force    = frc;
        force_re    = 9'(twr);
        force_im    = 9'(twi);
        #1;
        maddr = (v && fs) ? 0 : midx;
        checkOutput("tw_addr", int'(tw_addr), (eaddr >= 0) ? eaddr : maddr);
        if (v) begin
            if (useExp) begin
                e.re = er; e.im = ei; e.clip = eclip;
            end else begin
                e = model(re, im, frc ? twr : int'(rom_re[maddr]), frc ? twi : int'(rom_im[maddr]));
            end
            e.due = cycle + 3;
            sbq.push_back(e);
            if (fs) start_q.push_back(cycle + 1);
            midx = (maddr == 3) ? 0 : maddr + 1;
        end
    endtask

    task automatic addVec(input bit v, input bit fs, input bit frc, input int re, input int im,
                          input int twr, input int twi, input int addr,
                          input int er, input int ei, input bit clip);
        vec_t t;
        t.v = v; t.fs = fs; t.frc = frc; t.re = re; t.im = im; t.twr = twr; t.twi = twi;
        t.addr = addr; t.er = er; t.ei = ei; t.clip = clip;
        tbl.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            idle(1);
            guard++;
        end
        if (sbq.size() > 0) checkOutput("drain_timeout", sbq.size(), 0);
    endtask

    // Scoreboard and sat_flag model, sampled mid-cycle after each edge.
    always @(negedge clk) begin
        if (rst_n) begin
            sat_next = sat_model;
            evt = 1'b0;
            if (start_q.size() > 0 && start_q[0] == cycle) begin
                void'(start_q.pop_front());
                sat_next = 1'b0;
                evt = 1'b1;
            end
            if (dout_valid) begin
                evt = 1'b1;
                if (sbq.size() == 0) begin
                    checkOutput("dout_valid_unexpected", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("dout_latency", cycle, mon_e.due);
                    checkOutput("dout_re", int'(dout_re), mon_e.re);
                    checkOutput("dout_im", int'(dout_im), mon_e.im);
                    if (mon_e.clip) sat_next = 1'b1;
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cycle) begin
                mon_e = sbq.pop_front();
                checkOutput("dout_valid_missing", 0, 1);
            end
            if (evt) checkOutput("sat_flag", int'(sat_flag), int'(sat_next));
            sat_model = sat_next;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rom_re[0] = 128; rom_im[0] = 0;
        rom_re[1] = 128; rom_im[1] = 0;
        rom_re[2] = 128; rom_im[2] = 0;
        rom_re[3] = 0;   rom_im[3] = -128;

        // Frame of eight: (100,-50) through 1.0 x3 then -j.
        for (int i = 0; i < 8; i++)
            addVec(1, i == 0, 0, 100, -50, 0, 0, i % 4,
                   (i % 4 == 3) ? -50 : 100, (i % 4 == 3) ? -100 : -50, 0);
        // Saturation at idx3, then a new frame.
        addVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        addVec(1, 0, 0, -512, 0, 0, 0, 3, 0, 511, 1);
        addVec(1, 1, 0, 10, 10, 0, 0, 0, 10, 10, 0);
        // Valid pattern 1,0,0,1,1.
        addVec(1, 1, 0, 20, 30, 0, 0, 0, 20, 30, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        addVec(1, 0, 0, 20, 30, 0, 0, 1, 20, 30, 0);
        addVec(1, 0, 0, 20, 30, 0, 0, 2, 20, 30, 0);
        // Restart before the counter wraps, then run to idx3.
        addVec(1, 1, 0, 5, 7, 0, 0, 0, 5, 7, 0);
        addVec(1, 0, 0, 5, 7, 0, 0, 1, 5, 7, 0);
        addVec(1, 0, 0, 5, 7, 0, 0, 2, 5, 7, 0);
        addVec(1, 0, 0, 5, 7, 0, 0, 3, 7, -5, 0);
        // Forced twiddles: rounding of +-270/128 and a negative clip.
        addVec(1, 0, 1, 3, 0, 90, 0, 0, 2, 0, 0);
        addVec(1, 0, 1, -3, 0, 90, 0, 1, -2, 0, 0);
        addVec(1, 0, 1, -512, -512, 127, -128, 2, -512, 4, 1);
        addVec(1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // frame_start without din_valid must be ignored.
        addVec(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        addVec(1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0);

        rst_n = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
        din_re = '0; din_im = '0; tw_force = 1'b0; force_re = '0; force_im = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_dout_valid", int'(dout_valid), 0);
        checkOutput("reset_dout_re", int'(dout_re), 0);
        checkOutput("reset_dout_im", int'(dout_im), 0);
        checkOutput("reset_sat_flag", int'(sat_flag), 0);
        checkOutput("reset_tw_addr", int'(tw_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] vector table");
        foreach (tbl[i])
            applyStimulus(tbl[i].v, tbl[i].fs, tbl[i].re, tbl[i].im, tbl[i].frc,
                          tbl[i].twr, tbl[i].twi, tbl[i].addr, 1,
                          tbl[i].er, tbl[i].ei, tbl[i].clip);
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            bit v, fs, frc;
            int re, im, twr, twi;
            v   = ($urandom % 4) != 0;
            fs  = ($urandom % 8) == 0;
            frc = ($urandom % 2) == 0;
            re  = int'($urandom_range(0, 1023)) - 512;
            im  = int'($urandom_range(0, 1023)) - 512;
            twr = int'($urandom_range(0, 511)) - 256;
            twi = int'($urandom_range(0, 511)) - 256;
            applyStimulus(v, fs, re, im, frc, twr, twi, -1, 0, 0, 0, 0);
        end
        drain();

        $display("[TB] asynchronous reset with samples in flight");
        applyStimulus(1, 0, -512, -512, 1, 127, -128, -1, 0, 0, 0, 0);
        idle(3);
        applyStimulus(1, 0, 40, 40, 0, 0, 0, -1, 0, 0, 0, 0);
        applyStimulus(1, 0, 50, 50, 0, 0, 0, -1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        din_valid = 1'b0;
        rst_n = 1'b0;
        sbq.delete();
        start_q.delete();
        sat_model = 1'b0;
        midx = 0;
        #1;
        checkOutput("midreset_dout_valid", int'(dout_valid), 0);
        checkOutput("midreset_dout_re", int'(dout_re), 0);
        checkOutput("midreset_dout_im", int'(dout_im), 0);
        checkOutput("midreset_sat_flag", int'(sat_flag), 0);
        checkOutput("midreset_tw_addr", int'(tw_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("no_dout_after_reset", int'(dout_valid), 0);
        end
        applyStimulus(1, 0, 33, -44, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_tw_mul.md
Name: fft_tw_mul

Overview:
- Streaming complex twiddle multiplier for one radix-2 FFT stage, one sample per clock.
- Sits directly downstream of the stage butterfly and drives the address of the 4-entry stage twiddle ROM (9-bit Q2.7 re/im, combinational read).
- Multiplies each butterfly output by the twiddle selected by a per-frame sample counter, rounds, saturates, and forwards the product to the next stage.

Parameters:
- DIN_W, 10, signed width of input re/im.
- TW_W, 9, signed twiddle width (Q2.7; +1.0 = 128).
- TW_FRAC, 7, twiddle fractional bits; products are shifted right by this.
- DOUT_W, 10, signed width of output re/im.
- N_TW, 4, twiddle entries per frame; counter wraps at N_TW-1.
- ADDR_W, 2, twiddle address width, equal to clog2(N_TW).

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- din_valid  in  1  input sample valid
- frame_start  in  1  qualifies din_valid; marks sample 0 of a frame
- din_re  in  DIN_W  signed input real part
- din_im  in  DIN_W  signed input imaginary part
- tw_addr  out  ADDR_W  twiddle ROM address, combinational from counter and frame_start
- tw_re  in  TW_W  twiddle real part from ROM, same cycle as tw_addr
- tw_im  in  TW_W  twiddle imaginary part from ROM
- dout_valid  out  1  output sample valid
- dout_re  out  DOUT_W  signed product real part
- dout_im  out  DOUT_W  signed product imaginary part
- sat_flag  out  1  sticky: any output component saturated since reset or last frame_start

Behaviour:
- Reset (rst_n low, asynchronous): idx=0; all pipeline valids=0; dout_re/dout_im=0; dout_valid=0; sat_flag=0. Mid-frame reset drops all in-flight samples, and no dout_valid follows.
- Counter idx (ADDR_W bits):
  - tw_addr = 0 when din_valid&frame_start, else idx.
  - On din_valid: idx_next = (tw_addr==N_TW-1) ? 0 : tw_addr+1.
  - Without din_valid: idx holds. Gaps between samples are allowed.
  - frame_start without din_valid is ignored.
- Pipeline: fixed latency 3, no backpressure. A sample accepted at edge k yields dout_valid at edge k+3.
  - S1: register din_re, din_im, tw_re, tw_im, valid.
  - S2: register four signed products rr=re*twr, ii=im*twi, ri=re*twi, ir=im*twr (DIN_W+TW_W bits each).
  - S3: compute pre_re=rr-ii and pre_im=ri+ir at DIN_W+TW_W+1 bits. Round half-up: add 2^(TW_FRAC-1), then arithmetic shift right TW_FRAC. Saturate to DOUT_W signed range [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]. Register the result into dout_*.
- dout_re/dout_im hold their last value when dout_valid=0; they are not zeroed after reset release.
- sat_flag:
  - Set at the S3 register edge when either component of a valid sample clips.
  - Cleared when a frame_start sample is accepted at S1.
  - If clear and set fall on the same edge, set wins.
- Invalid S2/S3 slots never touch sat_flag.
- Back-to-back frames: frame_start may arrive on any valid sample, including before idx wraps. idx restarts and the prior partial frame is still output normally.

Test Plan:
- Reset then 8 consecutive valid samples, frame_start on sample 0 -> tw_addr sequence 0,1,2,3,0,1,2,3; first dout_valid exactly 3 cycles after first din_valid; no gaps.
- With ROM values (idx0..2 = (128,0), idx3 = (0,-128)), inputs (100,-50) on all four indices -> outputs (100,-50) x3, then (-50,-100).
- Input (-512,0) at idx3 -> raw im=+512 saturates to (0,511); sat_flag=1 on the same edge as dout_valid. Next frame_start sample clears sat_flag.
- Bench drives tw=(90,0) directly, din=(3,0) -> dout=(2,0). din=(-3,0) -> (-2,0), since -270+64=-206>>7=-2.
- din_valid toggled 1,0,0,1,1 -> idx advances only on valid cycles; dout_valid pattern is the input pattern delayed 3 cycles.
- rst_n asserted asynchronously mid-clock with 2 samples in flight -> dout_valid=0 and dout=0 immediately, no dout_valid after release; the next sample gets tw_addr=0 even without frame_start.
